sample_in_ball_engine: RTL and testbench
========================================

# sample_in_ball_engine

Streaming, level-parametrised SampleInBall core for ML-DSA. It consumes the SHAKE256 squeeze output of the H function as a byte stream with valid/ready flow control. It builds the challenge polynomial c in an internal coefficient array using the Fisher–Yates procedure, then streams all N coefficients out with index tags for a memory-write adapter. Tau is selected per level at run time; the coefficient output width and encoding are parameters.

## Interface
- `N`, 256: polynomial length. Legal values: powers of two, 64 ≤ N ≤ 256.
- `COEFF_W`, 24: output coefficient width.
- `Q`, 8380417: modulus used when `SIGNED_OUT`=0.
- `SIGNED_OUT`, 0: selects output encoding.
  - 0: -1 is emitted as Q-1.
  - 1: -1 is emitted as all-ones (two's complement).
- `TAU44`, `TAU65`, `TAU87`, 39 / 49 / 60: tau for each level. All must be ≤ N and ≤ 64.
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `start` in 1: one-cycle request. Sampled only in IDLE.
- `ml_dsa_level` in 2: level select, latched on an accepted start.
  - 00: ML-DSA-44.
  - 01: ML-DSA-65.
  - 10: ML-DSA-87.
  - 11: illegal.
- `byte_in` in 8: squeeze byte.
- `byte_valid` in 1: `byte_in` is valid.
- `byte_ready` out 1: engine can accept a byte.
- `out_coeff` out COEFF_W: coefficient value.
- `out_idx` out 8: coefficient index.
- `out_valid` out 1: `out_coeff` and `out_idx` are valid.
- `out_ready` in 1: sink accepts the current coefficient.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle pulse, coincident with `done`, on an illegal level.

## Operation
- Internal storage:
  - coefficient array, N entries × 2 bits: 00 = 0, 01 = +1, 11 = -1;
  - 64-bit sign register;
  - index counter `i`;
  - output counter.
- State IDLE:
  - `start`=1 with a legal level → SIGNS. The whole array is cleared to 0 on that same clock edge, and tau is latched.
  - `start`=1 with level 11 → ERR.
- State ERR: `done`=1 and `err`=1 for one cycle, then IDLE. No bytes are consumed and no output is produced.
- State SIGNS: `byte_ready`=1.
  - Accepts exactly 8 bytes (handshake = `byte_valid` & `byte_ready`).
  - Byte k is loaded into sign[8k+7:8k] (little-endian).
  - After the 8th accepted byte: `i` ← N-tau, then → SAMPLE.
- State SAMPLE: `byte_ready`=1. For each accepted byte j:
  - j > i: rejected. No state change.
  - j ≤ i:
    - c[i] ← c[j], then c[j] ← (sign[0] ? -1 : +1), in the same cycle. The c[j] write has priority, so j == i leaves c[i] = ±1.
    - The sign register shifts right by 1.
    - `i` increments.
  - The acceptance that processes i = N-1 moves the state to OUT.
- State OUT:
  - `out_valid`=1, `out_idx` = output counter, `out_coeff` = the encoded value of c[out_idx].
  - The counter advances on `out_valid` & `out_ready`.
  - The handshake at index N-1 moves the state to FIN.
  - `out_coeff` and `out_idx` hold stable while `out_ready`=0.
- State FIN: `done`=1 for one cycle, then IDLE. The array is retained until the next start.
- `start` is ignored in every state except IDLE.
- `byte_ready`=0 in IDLE, ERR, OUT and FIN.
- Output encoding:
  - 0 → 0;
  - +1 → 1;
  - -1 → Q-1 (`SIGNED_OUT`=0) or {COEFF_W{1}} (`SIGNED_OUT`=1).

## Timing
- Reset values (`rst_n`=0 at a clock edge):
  - state IDLE;
  - `byte_ready`, `out_valid`, `busy`, `done`, `err` = 0;
  - `out_coeff`, `out_idx` = 0;
  - counters and sign register = 0.
- Reset mid-operation aborts within that edge. Pending bytes are not consumed, and no `done` is issued.
- Start accepted at edge T: `busy`=1 and `byte_ready`=1 from T+1.
- Minimum latency from start to `done` = 1 + 8 + tau + N + 1 cycles, assuming continuous valid/ready and no rejections.
- Every accepted byte is consumed in exactly one cycle. There are no internal bubbles in SIGNS or SAMPLE.
- `out_valid` is driven from registered state only. It has no combinational dependence on `out_ready`.
- `done` is never asserted in the same cycle as `out_valid`.

## Test plan
- Level 00, sign bytes 05 00 00 00 00 00 00 00, then sample bytes FF, 10, D9 → FF rejected (i stays 217). Byte 10 gives c[217]=0 and c[16]=-1. Byte D9 gives c[218]=c[217]=0 and c[217]=+1 (sign bit 1 = 0).
- Full level-10 run (tau=60) against a golden-model stream, `SIGNED_OUT`=0 → exactly 60 nonzero coefficients, each equal to 1 or 8380416. `done` occurs exactly 1+8+accepted+256+1 cycles after start when the stream is continuous.
- Random `byte_valid` gaps and random `out_ready` backpressure → coefficient stream is identical to the continuous-stream run; `out_coeff` and `out_idx` hold while `out_ready`=0.
- `ml_dsa_level`=11 with `start` → `done`=`err`=1 at T+2, `byte_ready` never asserted, `out_valid` never asserted.
- `rst_n`=0 asserted mid-SAMPLE, then a new level-01 run → all outputs 0 the cycle after the reset edge. The new run yields exactly 49 nonzero coefficients, with no residue from the aborted run.
- `start` pulsed during SIGNS and during OUT → ignored. The current run completes unchanged with a single `done`.

Source files
------------

// File: rtl/sample_in_ball_engine.sv
// sample_in_ball_engine
//
// Streaming SampleInBall core for ML-DSA. It takes the SHAKE256 squeeze
// output of H as a byte stream and builds the challenge polynomial c in a
// local array of 2-bit trits using Fisher-Yates. It then streams all N
// coefficients out, tagged with their index.
//
// Ports
//   clk, rst_n          : clock, synchronous active-low reset
//   start, ml_dsa_level : run request (sampled in IDLE only) and level select
//                         00/01/10 = ML-DSA-44/65/87, 11 = illegal
//   byte_in, byte_valid : squeeze byte stream
//   byte_ready          : byte stream ready (SIGNS and SAMPLE only)
//   out_coeff, out_idx  : encoded coefficient and its index
//   out_valid/out_ready : coefficient stream handshake
//   busy                : engine not idle
//   done, err           : one-cycle completion pulse; err marks an illegal level
module sample_in_ball_engine #(
  parameter int N          = 256,
  parameter int COEFF_W    = 24,
  parameter int Q          = 8380417,
  parameter bit SIGNED_OUT = 1'b0,
  parameter int TAU44      = 39,
  parameter int TAU65      = 49,
  parameter int TAU87      = 60
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         ml_dsa_level,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic [COEFF_W-1:0] out_coeff,
  output logic [7:0]         out_idx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int IDX_W = $clog2(N);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  // Trit encoding of the coefficient array.
  localparam logic [1:0] C_ZERO = 2'b00;
  localparam logic [1:0] C_POS  = 2'b01;
  localparam logic [1:0] C_NEG  = 2'b11;

  localparam logic [COEFF_W-1:0] NEG_ENC =
    SIGNED_OUT ? {COEFF_W{1'b1}} : COEFF_W'(Q - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERR,
    S_SIGNS,
    S_SAMPLE,
    S_OUT,
    S_FIN
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] i_q, i_d;          // byte index in SIGNS, Fisher-Yates i in SAMPLE
  logic [IDX_W-1:0] out_cnt_q, out_cnt_d;
  logic [63:0]      sign_q, sign_d;
  logic [6:0]       tau_q, tau_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       c_q [N];
  logic [1:0]       c_d [N];

  logic [6:0]       tau_sel;
  logic             level_ok;
  logic [IDX_W-1:0] start_idx;
  logic [IDX_W-1:0] j_idx;
  logic             j_ok;
  logic [1:0]       cur_c;

  // Level decode for the start request.
  always_comb begin
    tau_sel  = 7'(TAU44);
    level_ok = 1'b1;
    case (ml_dsa_level)
      2'b00:   tau_sel = 7'(TAU44);
      2'b01:   tau_sel = 7'(TAU65);
      2'b10:   tau_sel = 7'(TAU87);
      default: level_ok = 1'b0;
    endcase
  end

  // First Fisher-Yates position N - tau. Modular arithmetic keeps this
  // correct when N - tau needs all IDX_W bits (e.g. N = 256).
  assign start_idx = LAST_IDX + IDX_W'(1) - IDX_W'(tau_q);

  // A sample byte j is usable only when j <= i. Bytes >= N fail this
  // test automatically, because i never exceeds N-1.
  assign j_idx = byte_in[IDX_W-1:0];
  assign j_ok  = (byte_in <= 8'(i_q));

  // NOTE: every variable written here gets its default first, so no path
  // can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    out_cnt_d = out_cnt_q;
    sign_d    = sign_q;
    tau_d     = tau_q;
    c_d       = c_q;
    // done/err are registered, so the pulse lands one cycle after ERR/FIN.
    done_d    = (state_q == S_ERR) || (state_q == S_FIN);
    err_d     = (state_q == S_ERR);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (level_ok) begin
            state_d   = S_SIGNS;
            tau_d     = tau_sel;
            i_d       = '0;
            out_cnt_d = '0;
            sign_d    = '0;
            c_d       = '{default: C_ZERO};
          end else begin
            state_d = S_ERR;
          end
        end
      end

      S_ERR: state_d = S_IDLE;

      S_SIGNS: begin
        if (byte_valid) begin
          // Little-endian: byte k fills sign[8k+7:8k].
          sign_d[{i_q[2:0], 3'b000} +: 8] = byte_in;
          if (i_q[2:0] == 3'd7) begin
            i_d     = start_idx;
            state_d = S_SAMPLE;
          end else begin
            i_d = i_q + IDX_W'(1);
          end
        end
      end

      S_SAMPLE: begin
        if (byte_valid && j_ok) begin
          // The c[j] write comes second, so it wins when j == i.
          c_d[i_q]   = c_q[j_idx];
          c_d[j_idx] = sign_q[0] ? C_NEG : C_POS;
          sign_d     = {1'b0, sign_q[63:1]};
          i_d        = i_q + IDX_W'(1);
          if (i_q == LAST_IDX) begin
            state_d = S_OUT;
          end
        end
      end

      S_OUT: begin
        if (out_ready) begin
          out_cnt_d = out_cnt_q + IDX_W'(1);
          if (out_cnt_q == LAST_IDX) begin
            state_d = S_FIN;
          end
        end
      end

      S_FIN: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      out_cnt_q <= '0;
      sign_q    <= '0;
      tau_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      out_cnt_q <= out_cnt_d;
      sign_q    <= sign_d;
      tau_q     <= tau_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // NOTE: the coefficient array has no reset. Every accepted start clears it,
  // and it is only read in OUT. It only holds while reset is applied, so an
  // aborted run cannot write to it on the reset edge.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      c_q <= c_d;
    end
  end

  // Outputs decode from registered state only. Nothing here depends
  // combinationally on out_ready.
  assign byte_ready = (state_q == S_SIGNS) || (state_q == S_SAMPLE);
  assign out_valid  = (state_q == S_OUT);
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign out_idx    = out_valid ? 8'(out_cnt_q) : 8'd0;
  assign cur_c      = c_q[out_cnt_q];

  always_comb begin
    out_coeff = '0;
    if (out_valid) begin
      case (cur_c)
        C_POS:   out_coeff = COEFF_W'(1);
        C_NEG:   out_coeff = NEG_ENC;
        default: out_coeff = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_in_ball_engine.sv
// Directed bench for sample_in_ball_engine (default parameters: N=256,
// Q=8380417, SIGNED_OUT=0).
module tb_sample_in_ball_engine;

  localparam int N   = 256;
  localparam int Q   = 8380417;
  localparam int T44 = 39;
  localparam int T65 = 49;
  localparam int T87 = 60;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  ml_dsa_level;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [23:0] out_coeff;
  logic [7:0]  out_idx;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        err;

  sample_in_ball_engine dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .ml_dsa_level (ml_dsa_level),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .out_coeff    (out_coeff),
    .out_idx      (out_idx),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] byte_q[$];
  int exp_c [N];
  int got_c [N];
  int ref_c [N];

  // Results of the last run_engine call.
  int done_cyc, done_cnt, err_cnt, overlap, hold_bad, order_bad, hs_total;
  logic busy1, rdy1;

  // Random sign bytes, then one sample byte per position, each drawn from
  // [0, i] so that no byte is rejected.
  function automatic void gen_stream(input int tau);
    byte_q.delete();
    for (int k = 0; k < 8; k++) byte_q.push_back(8'($urandom_range(0, 255)));
    for (int i = N - tau; i < N; i++) byte_q.push_back(8'($urandom_range(0, i)));
  endfunction

  // Reference SampleInBall over byte_q.
  function automatic void build_expected(input int tau);
    logic [63:0] s;
    int m [N];
    int i, j;
    for (int k = 0; k < N; k++) m[k] = 0;
    s = '0;
    for (int k = 0; k < 8; k++) s[8*k +: 8] = byte_q[k];
    i = N - tau;
    for (int k = 8; k < byte_q.size() && i < N; k++) begin
      j = int'(byte_q[k]);
      if (j <= i) begin
        m[i] = m[j];
        m[j] = s[0] ? -1 : 1;
        s    = s >> 1;
        i++;
      end
    end
    for (int k = 0; k < N; k++) exp_c[k] = (m[k] < 0) ? Q - 1 : m[k];
  endfunction

  function automatic int count_nonzero();
    int n = 0;
    for (int k = 0; k < N; k++) if (got_c[k] != 0) n++;
    return n;
  endfunction

  function automatic int count_illegal();
    int n = 0;
    for (int k = 0; k < N; k++)
      if (got_c[k] != 0 && got_c[k] != 1 && got_c[k] != Q - 1) n++;
    return n;
  endfunction

  function automatic int count_diff();
    int n = 0;
    for (int k = 0; k < N; k++) if (got_c[k] != exp_c[k]) n++;
    return n;
  endfunction

  // Start a run and drive byte_q until done is seen (plus 4 cycles).
  // cyc = 1 is the cycle after the start edge.
  task automatic run_engine(input logic [1:0] lvl, input bit gaps, input bit bp,
                            input bit poke);
    int cyc, bidx, hs, prev_idx, prev_coeff;
    bit prev_stall;
    for (int k = 0; k < N; k++) got_c[k] = -1;
    done_cyc = -1; done_cnt = 0; err_cnt = 0; overlap = 0;
    hold_bad = 0; order_bad = 0;
    bidx = 0; hs = 0; prev_stall = 1'b0; prev_idx = 0; prev_coeff = 0;
    @(negedge clk);
    start = 1'b1; ml_dsa_level = lvl; out_ready = 1'b1; byte_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    busy1 = busy;
    rdy1  = byte_ready;
    while (cyc < 4000) begin
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        if (err) err_cnt++;
      end
      if (done && out_valid) overlap++;
      if (prev_stall && (int'(out_idx) != prev_idx || int'(out_coeff) != prev_coeff || !out_valid))
        hold_bad++;
      if (out_valid) begin
        if (int'(out_idx) != hs) order_bad++;
        got_c[out_idx] = int'(out_coeff);
      end
      byte_valid = 1'b0;
      if (bidx < byte_q.size() && !(gaps && $urandom_range(0, 2) == 0)) begin
        byte_valid = 1'b1;
        byte_in    = byte_q[bidx];
        if (byte_ready) bidx++;
      end
      out_ready = !(bp && $urandom_range(0, 2) == 0);
      if (out_valid && out_ready) hs++;
      prev_stall   = out_valid && !out_ready;
      prev_idx     = int'(out_idx);
      prev_coeff   = int'(out_coeff);
      start        = poke && (cyc == 3 || cyc == 150);
      ml_dsa_level = poke ? 2'b11 : lvl;
      if (done_cyc > 0 && cyc >= done_cyc + 4) break;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; byte_valid = 1'b0; out_ready = 1'b1;
    hs_total = hs;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; ml_dsa_level = 2'b00;
    byte_valid = 1'b1; byte_in = 8'h00; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL rst_byte_ready got=%b exp=0", byte_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if ({busy, done, err} !== 3'b000) begin bad++; $display("FAIL rst_busy_done_err got=%b exp=000", {busy, done, err}); end
    total++; if (out_coeff !== 24'd0 || out_idx !== 8'd0) begin bad++; $display("FAIL rst_out_data got=%h/%h exp=0/0", out_coeff, out_idx); end
    start = 1'b0; byte_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Signs 05 00.., samples FF 10 D9, then j = i for i = 219..255.
  // Result: c[16]=-1, c[217]=+1, c[218]=0, c[219]=-1, c[220..255]=+1.
  function automatic void set_directed();
    byte_q.delete();
    byte_q.push_back(8'h05);
    for (int k = 0; k < 7; k++) byte_q.push_back(8'h00);
    byte_q.push_back(8'hFF);
    byte_q.push_back(8'h10);
    byte_q.push_back(8'hD9);
    for (int i = 219; i < N; i++) byte_q.push_back(8'(i));
    for (int k = 0; k < N; k++) exp_c[k] = 0;
    exp_c[16]  = Q - 1;
    exp_c[217] = 1;
    exp_c[219] = Q - 1;
    for (int k = 220; k < N; k++) exp_c[k] = 1;
  endfunction

  task automatic test_directed_vector();
    set_directed();
    run_engine(2'b00, 1'b0, 1'b0, 1'b0);
    total++; if (busy1 !== 1'b1 || rdy1 !== 1'b1) begin bad++; $display("FAIL dir_busy_ready_t1 got=%b%b exp=11", busy1, rdy1); end
    total++; if (got_c[16] != Q - 1) begin bad++; $display("FAIL dir_c16 got=%0d exp=%0d", got_c[16], Q - 1); end
    total++; if (got_c[217] != 1) begin bad++; $display("FAIL dir_c217 got=%0d exp=1", got_c[217]); end
    total++; if (got_c[218] != 0) begin bad++; $display("FAIL dir_c218 got=%0d exp=0", got_c[218]); end
    total++; if (count_diff() != 0) begin bad++; $display("FAIL dir_stream diffs=%0d exp=0", count_diff()); end
    total++; if (count_nonzero() != T44) begin bad++; $display("FAIL dir_nonzero got=%0d exp=%0d", count_nonzero(), T44); end
    // 40 sample bytes: 39 accepted plus one rejected, one cycle each.
    total++; if (done_cyc != 1 + 8 + 40 + N + 1) begin bad++; $display("FAIL dir_latency got=%0d exp=%0d", done_cyc, 1 + 8 + 40 + N + 1); end
    total++; if (done_cnt != 1 || err_cnt != 0) begin bad++; $display("FAIL dir_done_pulse got=%0d/%0d exp=1/0", done_cnt, err_cnt); end
    total++; if (hs_total != N || order_bad != 0 || overlap != 0) begin bad++; $display("FAIL dir_out_seq hs=%0d order=%0d overlap=%0d exp=%0d/0/0", hs_total, order_bad, overlap, N); end
  endtask

  task automatic test_start_ignored();
    set_directed();
    run_engine(2'b00, 1'b0, 1'b0, 1'b1);
    total++; if (count_diff() != 0) begin bad++; $display("FAIL poke_stream diffs=%0d exp=0", count_diff()); end
    total++; if (done_cnt != 1 || err_cnt != 0) begin bad++; $display("FAIL poke_done got=%0d/%0d exp=1/0", done_cnt, err_cnt); end
    total++; if (done_cyc != 1 + 8 + 40 + N + 1) begin bad++; $display("FAIL poke_latency got=%0d exp=%0d", done_cyc, 1 + 8 + 40 + N + 1); end
  endtask

  task automatic test_level87_golden();
    gen_stream(T87);
    build_expected(T87);
    run_engine(2'b10, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < N; k++) ref_c[k] = got_c[k];
    total++; if (count_nonzero() != T87) begin bad++; $display("FAIL l87_nonzero got=%0d exp=%0d", count_nonzero(), T87); end
    total++; if (count_illegal() != 0) begin bad++; $display("FAIL l87_values bad_values=%0d exp=0", count_illegal()); end
    total++; if (count_diff() != 0) begin bad++; $display("FAIL l87_stream diffs=%0d exp=0", count_diff()); end
    total++; if (done_cyc != 1 + 8 + T87 + N + 1) begin bad++; $display("FAIL l87_latency got=%0d exp=%0d", done_cyc, 1 + 8 + T87 + N + 1); end
    total++; if (done_cnt != 1 || overlap != 0) begin bad++; $display("FAIL l87_done got=%0d overlap=%0d exp=1/0", done_cnt, overlap); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    run_engine(2'b10, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < N; k++) if (got_c[k] != ref_c[k]) n++;
    total++; if (n != 0) begin bad++; $display("FAIL bp_vs_continuous diffs=%0d exp=0", n); end
    total++; if (hold_bad != 0) begin bad++; $display("FAIL bp_hold violations=%0d exp=0", hold_bad); end
    total++; if (hs_total != N || order_bad != 0) begin bad++; $display("FAIL bp_out_seq hs=%0d order=%0d exp=%0d/0", hs_total, order_bad, N); end
    total++; if (done_cnt != 1 || overlap != 0) begin bad++; $display("FAIL bp_done got=%0d overlap=%0d exp=1/0", done_cnt, overlap); end
  endtask

  task automatic test_illegal_level();
    int done_at = -1, err_at = -1, ndone = 0;
    bit rdy_seen = 1'b0, ov_seen = 1'b0;
    @(negedge clk);
    start = 1'b1; ml_dsa_level = 2'b11; byte_valid = 1'b1; byte_in = 8'h00; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (done) begin ndone++; if (done_at < 0) done_at = c; end
      if (err && err_at < 0) err_at = c;
      rdy_seen |= byte_ready;
      ov_seen  |= out_valid;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    total++; if (done_at != 2 || err_at != 2) begin bad++; $display("FAIL err_timing done_at=%0d err_at=%0d exp=2/2", done_at, err_at); end
    total++; if (ndone != 1) begin bad++; $display("FAIL err_pulse got=%0d exp=1", ndone); end
    total++; if (rdy_seen || ov_seen) begin bad++; $display("FAIL err_no_traffic ready=%b valid=%b exp=0/0", rdy_seen, ov_seen); end
  endtask

  task automatic test_reset_abort();
    gen_stream(T87);
    @(negedge clk);
    start = 1'b1; ml_dsa_level = 2'b10; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 13; k++) begin
      byte_valid = 1'b1; byte_in = byte_q[k];
      @(negedge clk);
    end
    total++; if (busy !== 1'b1 || byte_ready !== 1'b1) begin bad++; $display("FAIL abort_mid_sample got=%b%b exp=11", busy, byte_ready); end
    rst_n = 1'b0; byte_valid = 1'b1; byte_in = 8'h00;
    @(negedge clk);
    total++; if ({byte_ready, out_valid, busy, done, err} !== 5'b0) begin bad++; $display("FAIL abort_flags got=%b exp=00000", {byte_ready, out_valid, busy, done, err}); end
    total++; if (out_coeff !== 24'd0 || out_idx !== 8'd0) begin bad++; $display("FAIL abort_data got=%h/%h exp=0/0", out_coeff, out_idx); end
    rst_n = 1'b1; byte_valid = 1'b0;
    @(negedge clk);
    gen_stream(T65);
    build_expected(T65);
    run_engine(2'b01, 1'b0, 1'b0, 1'b0);
    total++; if (count_nonzero() != T65) begin bad++; $display("FAIL l65_nonzero got=%0d exp=%0d", count_nonzero(), T65); end
    total++; if (count_diff() != 0) begin bad++; $display("FAIL l65_stream diffs=%0d exp=0", count_diff()); end
    total++; if (done_cnt != 1 || err_cnt != 0) begin bad++; $display("FAIL l65_done got=%0d/%0d exp=1/0", done_cnt, err_cnt); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ml_dsa_level = 2'b00;
    byte_in = 8'h00; byte_valid = 1'b0; out_ready = 1'b1;
    test_reset();
    test_directed_vector();
    test_start_ignored();
    test_level87_golden();
    test_backpressure();
    test_illegal_level();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
